conv1d_stream_pe: RTL and testbench

//  Parametrised successor of the fixed-filter conv layers: 1-D valid-mode convolution of a LENX-sample

---
 rtl/conv_pkg.sv | 28 ++
 rtl/mac_lane.sv | 48 ++++
 rtl/conv1d_stream_pe.sv | 178 +++++++++++++++++
 tb/tb_conv1d_stream_pe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming 1-D convolution PE.
package conv_pkg;

  typedef enum logic [1:0] {LOAD_F, LOAD_X, COMPUTE, DRAIN} state_t;

  // Bits needed to index n entries, never less than 1.
  function automatic int unsigned cw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Number of lane groups needed to cover size outputs with p lanes.
  function automatic int unsigned num_groups(input int unsigned size, input int unsigned p);
    return (size + p - 1) / p;
  endfunction

  // Clamp a wide signed accumulator to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] acc,
                                               input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = ~hi;
    if (acc > hi)      return hi;
    else if (acc < lo) return lo;
    else               return acc;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One multiply-accumulate lane with a registered saturating output stage.
// Build option: RELU_EN clamps negative saturated results to zero.
module mac_lane import conv_pkg::*; #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ACCW  = 36
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    out_en,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] f_in,
  output logic signed [WIDTH-1:0] y
);

  localparam int unsigned PW = 2 * WIDTH;

  logic signed [PW-1:0]   prod_c;
  logic signed [ACCW-1:0] acc;
  logic signed [63:0]     sat_c;

  assign prod_c = PW'(x_in) * PW'(f_in);
  assign sat_c  = sat_w(64'(acc), WIDTH);

  // Accumulate one product per enabled cycle; clr restarts the sum with the current product.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? ACCW'(prod_c) : acc + ACCW'(prod_c);
    end
  end

  // Capture the finished, saturated sum as this lane's output-buffer entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      y <= '0;
    end else if (out_en) begin
`ifdef RELU_EN
      y <= sat_c[63] ? '0 : WIDTH'(sat_c);
`else
      y <= WIDTH'(sat_c);
`endif
    end
  end

endmodule

// File: rtl/conv1d_stream_pe.sv
// Streaming valid-mode 1-D convolution with run-time filter taps and P MAC lanes.
// Build option: RELU_EN fuses a ReLU after output saturation.
module conv1d_stream_pe import conv_pkg::*; #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LENX  = 32,
  parameter int unsigned LENF  = 9,
  parameter int unsigned P     = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in_f,
  input  logic                    s_valid_f,
  output logic                    s_ready_f,
  input  logic signed [WIDTH-1:0] s_data_in_x,
  input  logic                    s_valid_x,
  output logic                    s_ready_x,
  output logic signed [WIDTH-1:0] m_data_out_y,
  output logic                    m_valid_y,
  input  logic                    m_ready_y
);

  localparam int unsigned ACCW = 2 * WIDTH + $clog2(LENF);
  localparam int unsigned SIZE = LENX - LENF + 1;
  localparam int unsigned NG   = num_groups(SIZE, P);
  localparam int unsigned XAW  = cw(LENX);
  localparam int unsigned FAW  = cw(LENF);
  localparam int unsigned PAW  = cw(P);
  localparam int unsigned IW   = cw(P + 1);
  localparam int unsigned GW   = cw(NG);
  localparam int unsigned CNTW = cw(LENX + LENF + 2);

  state_t                 state;
  logic [CNTW-1:0]        cnt;
  logic [GW-1:0]          grp;
  logic [IW-1:0]          rd_idx;

  logic signed [WIDTH-1:0] f_mem  [LENF];
  logic signed [WIDTH-1:0] x_mem  [LENX];
  logic signed [WIDTH-1:0] x_rd_c [P];
  logic signed [WIDTH-1:0] xr     [P];
  logic signed [WIDTH-1:0] fr;
  logic signed [WIDTH-1:0] lane_y [P];
  logic [P-1:0]            rd_en;
  logic                    rd_first;

  logic            tap_fire_c, smp_fire_c, load_buf_c, last_grp_c;
  logic [IW-1:0]   emit_cnt_c;

  assign tap_fire_c = s_valid_f & s_ready_f;
  assign smp_fire_c = s_valid_x & s_ready_x;
  assign load_buf_c = (state == COMPUTE) && (cnt == CNTW'(LENF + 1));
  assign last_grp_c = (grp == GW'(NG - 1));

  // Outputs produced by the current group; the final group may be partial.
  always_comb begin
    emit_cnt_c = IW'(P);
    if (SIZE - 32'(grp) * P < P) emit_cnt_c = IW'(SIZE - 32'(grp) * P);
  end

  // P parallel read ports into the sample memory; out-of-frame reads return zero.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      x_rd_c[i] = '0;
      if (32'(grp) * P + 32'(i) + 32'(cnt) < LENX)
        x_rd_c[i] = x_mem[XAW'(32'(grp) * P + 32'(i) + 32'(cnt))];
    end
  end

  // Tap and sample storage written on accepted transfers.
  always_ff @(posedge clk) begin
    if (tap_fire_c) f_mem[FAW'(cnt)] <= s_data_in_f;
    if (smp_fire_c) x_mem[XAW'(cnt)] <= s_data_in_x;
  end

  // Registered read stage feeding the lanes with x window and current tap.
  always_ff @(posedge clk) begin
    if ((state == COMPUTE) && (cnt < CNTW'(LENF))) begin
      fr <= f_mem[FAW'(cnt)];
      for (int i = 0; i < P; i++) xr[i] <= x_rd_c[i];
    end
  end

  // Lane enables follow the read stage by one cycle; lanes past the last output stay idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en    <= '0;
      rd_first <= 1'b0;
    end else begin
      for (int i = 0; i < P; i++)
        rd_en[i] <= (state == COMPUTE) && (cnt < CNTW'(LENF)) && (32'(grp) * P + 32'(i) < SIZE);
      rd_first <= (state == COMPUTE) && (cnt == '0);
    end
  end

  for (genvar i = 0; i < P; i++) begin : g_lane
    mac_lane #(.WIDTH(WIDTH), .ACCW(ACCW)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .clr    (rd_first),
      .en     (rd_en[i]),
      .out_en (load_buf_c),
      .x_in   (xr[i]),
      .f_in   (fr),
      .y      (lane_y[i])
    );
  end

  // Control FSM with registered handshake outputs and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LOAD_F;
      cnt          <= '0;
      grp          <= '0;
      rd_idx       <= '0;
      s_ready_f    <= 1'b1;
      s_ready_x    <= 1'b0;
      m_valid_y    <= 1'b0;
      m_data_out_y <= '0;
    end else begin
      case (state)
        LOAD_F: begin
          if (tap_fire_c) begin
            if (cnt == CNTW'(LENF - 1)) begin
              cnt       <= '0;
              state     <= LOAD_X;
              s_ready_f <= 1'b0;
              s_ready_x <= 1'b1;
            end else begin
              cnt <= cnt + CNTW'(1);
            end
          end
        end
        LOAD_X: begin
          if (smp_fire_c) begin
            if (cnt == CNTW'(LENX - 1)) begin
              cnt       <= '0;
              grp       <= '0;
              state     <= COMPUTE;
              s_ready_x <= 1'b0;
            end else begin
              cnt <= cnt + CNTW'(1);
            end
          end
        end
        COMPUTE: begin
          if (load_buf_c) begin
            cnt    <= '0;
            rd_idx <= '0;
            state  <= DRAIN;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        DRAIN: begin
          if (!m_valid_y || m_ready_y) begin
            if (rd_idx < emit_cnt_c) begin
              m_data_out_y <= lane_y[PAW'(rd_idx)];
              m_valid_y    <= 1'b1;
              rd_idx       <= rd_idx + IW'(1);
            end else if (m_valid_y) begin
              m_valid_y <= 1'b0;
              if (last_grp_c) begin
                grp       <= '0;
                state     <= LOAD_X;
                s_ready_x <= 1'b1;
              end else begin
                grp   <= grp + GW'(1);
                state <= COMPUTE;
              end
            end
          end
        end
        default: state <= LOAD_F;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_stream_pe.sv
// Self-checking bench for conv1d_stream_pe: table-driven frames against a plain-arithmetic model.
module tb_conv1d_stream_pe;

  localparam int unsigned W    = 16;
  localparam int unsigned LENX = 32;
  localparam int unsigned LENF = 9;
  localparam int unsigned PA   = 12;
  localparam int unsigned PB   = 5;
  localparam int unsigned SIZE = LENX - LENF + 1;
`ifdef RELU_EN
  localparam longint NEG_SAT = 0;
`else
  localparam longint NEG_SAT = -32768;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  logic signed [W-1:0] f_d, x_d;
  logic f_v, x_v, y_r;
  logic rf_a, rx_a, vy_a, rf_b, rx_b, vy_b;
  logic signed [W-1:0] y_a, y_b;
  logic rf, rx, vy;
  logic signed [W-1:0] yd;

  assign rf = sel ? rf_b : rf_a;
  assign rx = sel ? rx_b : rx_a;
  assign vy = sel ? vy_b : vy_a;
  assign yd = sel ? y_b  : y_a;

  always #5 clk = ~clk;

  conv1d_stream_pe #(.WIDTH(W), .LENX(LENX), .LENF(LENF), .P(PA)) dut (
    .clk(clk), .reset(reset),
    .s_data_in_f(f_d), .s_valid_f(f_v & ~sel), .s_ready_f(rf_a),
    .s_data_in_x(x_d), .s_valid_x(x_v & ~sel), .s_ready_x(rx_a),
    .m_data_out_y(y_a), .m_valid_y(vy_a), .m_ready_y(y_r & ~sel)
  );

  conv1d_stream_pe #(.WIDTH(W), .LENX(LENX), .LENF(LENF), .P(PB)) dut5 (
    .clk(clk), .reset(reset),
    .s_data_in_f(f_d), .s_valid_f(f_v & sel), .s_ready_f(rf_b),
    .s_data_in_x(x_d), .s_valid_x(x_v & sel), .s_ready_x(rx_b),
    .m_data_out_y(y_b), .m_valid_y(vy_b), .m_ready_y(y_r & sel)
  );

  int n_vec = 0;
  int n_err = 0;
  longint fm [LENF];
  longint xm [LENX];
  longint exp_y [SIZE];
  longint got_y [SIZE];

  typedef struct {
    int     fk;
    int     xk;
    bit     reload;
    int     rdy;
    bit     tab;
    longint y0;
    longint yl;
  } vec_t;
  vec_t tv [8];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: direct valid-mode convolution, then clamp and optional ReLU.
  function automatic void model();
    longint hi, lo, s;
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -hi - 1;
    for (int n = 0; n < SIZE; n++) begin
      s = 0;
      for (int k = 0; k < LENF; k++) s += xm[n + k] * fm[k];
      if (s > hi) s = hi;
      if (s < lo) s = lo;
`ifdef RELU_EN
      if (s < 0) s = 0;
`endif
      exp_y[n] = s;
    end
  endfunction

  function automatic longint rnd_w();
    return longint'($signed(W'($urandom)));
  endfunction

  function automatic void fill_f(input int fk);
    for (int k = 0; k < LENF; k++)
      case (fk)
        0: fm[k] = (k == 0) ? 1 : 0;
        1: fm[k] = 32767;
        2: fm[k] = 1;
        3: fm[k] = k;
        4: fm[k] = (k == LENF - 1) ? 1 : 0;
        default: fm[k] = rnd_w();
      endcase
  endfunction

  function automatic void fill_x(input int xk);
    for (int n = 0; n < LENX; n++)
      case (xk)
        0: xm[n] = n;
        1: xm[n] = 32767;
        2: xm[n] = -32767;
        3: xm[n] = 1;
        default: xm[n] = rnd_w();
      endcase
  endfunction

  task automatic do_reset();
    f_v = 1'b0; x_v = 1'b0; y_r = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_f(input longint v);
    int t = 0;
    f_d = W'(v); f_v = 1'b1;
    while (!rf && t < 100) begin @(negedge clk); t++; end
    if (!rf) chk("tap_ready_timeout", 64'(rf), 1);
    @(negedge clk);
    f_v = 1'b0;
  endtask

  task automatic push_x(input longint v, input int gap);
    int t = 0;
    x_v = 1'b0;
    while ($urandom_range(99) < gap) @(negedge clk);
    x_d = W'(v); x_v = 1'b1;
    while (!rx && t < 100) begin @(negedge clk); t++; end
    if (!rx) chk("smp_ready_timeout", 64'(rx), 1);
    @(negedge clk);
    x_v = 1'b0;
  endtask

  task automatic load_taps();
    for (int k = 0; k < LENF; k++) push_f(fm[k]);
  endtask

  // Drain n outputs under random backpressure, checking values and stall stability.
  task automatic collect(input int n, input int rdy);
    int got = 0;
    int t = 0;
    bit hold = 0;
    logic signed [W-1:0] hd = '0;
    while (got < n && t < 3000) begin
      if (hold) begin
        chk("stall_valid", 64'(vy), 1);
        chk("stall_data", yd, hd);
      end
      y_r = ($urandom_range(99) < rdy);
      hold = 0;
      if (vy) begin
        if (y_r) begin
          chk($sformatf("y[%0d]", got), yd, exp_y[got]);
          got_y[got] = yd;
          got++;
        end else begin
          hold = 1;
          hd = yd;
        end
      end
      @(negedge clk);
      t++;
    end
    y_r = 1'b0;
    chk("out_count", got, n);
  endtask

  task automatic run_frame(input int rdy, input int gap);
    int t = 0;
    model();
    for (int n = 0; n < LENX; n++) push_x(xm[n], gap);
    while (!vy && t < 200) begin @(negedge clk); t++; end
    chk("first_latency", t, LENF + 3);
    collect(SIZE, rdy);
    chk("tail_valid", 64'(vy), 0);
    chk("tail_ready_x", 64'(rx), 1);
    chk("tail_ready_f", 64'(rf), 0);
  endtask

  initial begin
    f_d = '0; x_d = '0; f_v = 1'b0; x_v = 1'b0; y_r = 1'b0;

    tv[0] = '{0, 0, 1, 100, 1, 0, 23};
    tv[1] = '{1, 1, 1,  70, 1, 32767, 32767};
    tv[2] = '{1, 2, 0,  60, 1, NEG_SAT, NEG_SAT};
    tv[3] = '{2, 3, 1,  50, 1, 9, 9};
    tv[4] = '{3, 3, 1, 100, 1, 36, 36};
    tv[5] = '{4, 0, 1,  40, 1, 8, 31};
    tv[6] = '{5, 4, 1,  50, 0, 0, 0};
    tv[7] = '{5, 4, 0,  30, 0, 0, 0};

    do_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_ready_f", 64'(rf), 1);
      chk("rst_ready_x", 64'(rx), 0);
      chk("rst_valid_y", 64'(vy), 0);
      chk("rst_data_y", yd, 0);
    end
    sel = 1'b0;

    for (int r = 0; r < 8; r++) begin
      if (tv[r].reload) begin
        fill_f(tv[r].fk);
        do_reset();
        load_taps();
      end
      fill_x(tv[r].xk);
      run_frame(tv[r].rdy, 20);
      if (tv[r].tab) begin
        chk($sformatf("row%0d_y0", r), got_y[0], tv[r].y0);
        chk($sformatf("row%0d_ylast", r), got_y[SIZE - 1], tv[r].yl);
      end
    end

    // Narrow configuration: five groups, the last one partial.
    sel = 1'b1;
    fill_f(5);
    do_reset();
    load_taps();
    fill_x(4);
    run_frame(60, 10);
    fill_x(0);
    run_frame(100, 0);

    // Reset partway through a frame, ignored samples while loading taps, then full reload.
    sel = 1'b0;
    fill_f(5);
    do_reset();
    load_taps();
    fill_x(4);
    for (int n = 0; n < 10; n++) push_x(xm[n], 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready_f", 64'(rf), 1);
    chk("midrst_valid_y", 64'(vy), 0);
    chk("midrst_ready_x", 64'(rx), 0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      x_d = W'(rnd_w()); x_v = 1'b1;
      @(negedge clk);
      chk("loadf_ready_x", 64'(rx), 0);
    end
    x_v = 1'b0;
    fill_f(5);
    load_taps();
    fill_x(4);
    run_frame(50, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
